// File: rtl/memory_access_pkg.sv
// memory_access_pkg
//   Types and helpers shared by the memory-access stage and its sub-modules:
//   stage FSM encoding, opcode encoding, the inter-stage content_t bundle,
//   byte-strobe base patterns and load/store opcode predicates.
package memory_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    typedef enum logic [3:0] {
        OP_ADDU = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8,
        OP_OR   = 4'd9
    } op_t;

    // Bundle passed Execute -> Memory -> Writeback.
    // valE: ALU result / effective address, valB: store data, valM: load result.
    typedef struct packed {
        op_t         opcode;
        logic [4:0]  dst;
        logic [31:0] valE;
        logic [31:0] valB;
        logic [31:0] valM;
    } content_t;

    // Strobe base patterns, shifted into the addressed lane by the aligner.
    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    function automatic logic is_load(op_t op);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: is_load = 1'b1;
            default:                             is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(op_t op);
        case (op)
            OP_SB, OP_SH, OP_SW: is_store = 1'b1;
            default:             is_store = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// memory_access_if
//   Data-bus request/response channel between the memory-access stage
//   (master) and the data memory / cache (slave).
//   dreq_valid/dreq_addr/dreq_wen/dreq_wdata : request, held until daddr_ok
//   daddr_ok : slave accepted the request this cycle
//   ddata_ok : slave completed the transaction this cycle, drdata valid
interface memory_access_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              dreq_valid;
    logic [ADDR_W-1:0] dreq_addr;
    logic [3:0]        dreq_wen;
    logic [DATA_W-1:0] dreq_wdata;
    logic              daddr_ok;
    logic              ddata_ok;
    logic [DATA_W-1:0] drdata;

    modport master (
        output dreq_valid, dreq_addr, dreq_wen, dreq_wdata,
        input  daddr_ok, ddata_ok, drdata
    );

    modport slave (
        input  dreq_valid, dreq_addr, dreq_wen, dreq_wdata,
        output daddr_ok, ddata_ok, drdata
    );
endinterface

// File: rtl/memory_access_mem_align.sv
// memory_access_mem_align
//   Combinational lane logic for byte/half/word accesses on a 32-bit bus.
//   Inputs : opcode, addr_lo (address bits [1:0]), valb (store data),
//            drdata (bus read data)
//   Outputs: wen (byte strobes, zero for loads), wdata (lane-replicated store
//            data), valm (aligned and extended load data, zero otherwise),
//            misalign (address not aligned to the access size)
module memory_access_mem_align
    import memory_access_pkg::*;
(
    input  op_t         opcode,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] valb,
    input  logic [31:0] drdata,
    output logic [3:0]  wen,
    output logic [31:0] wdata,
    output logic [31:0] valm,
    output logic        misalign
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and half-word out of the read word.
    always_comb begin
        byte_s = drdata[{addr_lo, 3'b000} +: 8];
        half_s = drdata[{addr_lo[1], 4'b0000} +: 16];
    end

    // Per-opcode strobes, store replication, load extension and misalignment;
    // a misaligned access yields no strobes and a zero result.
    always_comb begin
        wen      = 4'b0000;
        wdata    = 32'h0000_0000;
        valm     = 32'h0000_0000;
        misalign = 1'b0;
        case (opcode)
            OP_LB:  valm = {{24{byte_s[7]}}, byte_s};
            OP_LBU: valm = {24'h00_0000, byte_s};
            OP_LH: begin
                misalign = addr_lo[0];
                valm     = misalign ? 32'h0000_0000 : {{16{half_s[15]}}, half_s};
            end
            OP_LHU: begin
                misalign = addr_lo[0];
                valm     = misalign ? 32'h0000_0000 : {16'h0000, half_s};
            end
            OP_LW: begin
                misalign = (addr_lo != 2'b00);
                valm     = misalign ? 32'h0000_0000 : drdata;
            end
            OP_SB: begin
                wen   = STRB_B << addr_lo;
                wdata = {4{valb[7:0]}};
            end
            OP_SH: begin
                misalign = addr_lo[0];
                wen      = misalign ? 4'b0000 : (STRB_H << {addr_lo[1], 1'b0});
                wdata    = {2{valb[15:0]}};
            end
            OP_SW: begin
                misalign = (addr_lo != 2'b00);
                wen      = misalign ? 4'b0000 : STRB_W;
                wdata    = valb;
            end
            default: begin
                wen      = 4'b0000;
                wdata    = 32'h0000_0000;
                valm     = 32'h0000_0000;
                misalign = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// memory_access
//   Pipeline stage after Execute. Non-memory instructions pass to Writeback
//   after one register stage; loads/stores run one request/response
//   transaction on the data bus and return aligned/extended load data in valM.
//   clk, resetn       : clock, synchronous active-low reset
//   in_valid, in_cont : instruction from Execute (held by upstream while busy)
//   busy              : stage occupied, upstream must stall
//   out_valid, out_cont, out_misalign : one-cycle result to Writeback
//   dbus              : data-bus master port
module memory_access
    import memory_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    input  content_t          in_cont,
    output logic              busy,
    output logic              out_valid,
    output content_t          out_cont,
    output logic              out_misalign,
    memory_access_if.master   dbus
);

    mem_state_t        state_r;
    content_t          cont_r;
    content_t          out_cont_r;
    content_t          accept_cont_s;
    content_t          done_cont_s;
    logic              busy_r;
    logic              out_valid_r;
    logic              out_misalign_r;
    logic              dreq_valid_r;
    logic [ADDR_W-1:0] dreq_addr_r;
    logic [3:0]        dreq_wen_r;
    logic [DATA_W-1:0] dreq_wdata_r;

    op_t               al_op_s;
    logic [1:0]        al_addr_s;
    logic [31:0]       al_valb_s;
    logic [3:0]        al_wen_s;
    logic [31:0]       al_wdata_s;
    logic [31:0]       al_valm_s;
    logic              al_misalign_s;
    logic              mem_op_s;

    // The aligner looks at the incoming bundle while IDLE (misalignment and
    // request fields) and at the latched bundle afterwards (load response).
    always_comb begin
        if (state_r == IDLE) begin
            al_op_s   = in_cont.opcode;
            al_addr_s = in_cont.valE[1:0];
            al_valb_s = in_cont.valB;
        end else begin
            al_op_s   = cont_r.opcode;
            al_addr_s = cont_r.valE[1:0];
            al_valb_s = cont_r.valB;
        end
    end

    memory_access_mem_align u_align (
        .opcode   (al_op_s),
        .addr_lo  (al_addr_s),
        .valb     (al_valb_s),
        .drdata   (dbus.drdata),
        .wen      (al_wen_s),
        .wdata    (al_wdata_s),
        .valm     (al_valm_s),
        .misalign (al_misalign_s)
    );

    // Result bundles: straight-through acceptance (non-memory keeps its valM,
    // misaligned memory op gets zero) and bus completion (aligner's valM).
    always_comb begin
        mem_op_s      = is_load(in_cont.opcode) || is_store(in_cont.opcode);
        accept_cont_s = in_cont;
        if (mem_op_s) begin
            accept_cont_s.valM = 32'h0000_0000;
        end else begin
            accept_cont_s.valM = in_cont.valM;
        end
        done_cont_s      = cont_r;
        done_cont_s.valM = al_valm_s;
    end

    // Stage FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r        <= IDLE;
            cont_r         <= '0;
            out_cont_r     <= '0;
            busy_r         <= 1'b0;
            out_valid_r    <= 1'b0;
            out_misalign_r <= 1'b0;
            dreq_valid_r   <= 1'b0;
            dreq_addr_r    <= '0;
            dreq_wen_r     <= 4'b0000;
            dreq_wdata_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    out_valid_r    <= 1'b0;
                    out_misalign_r <= 1'b0;
                    if (in_valid) begin
                        cont_r <= in_cont;
                        busy_r <= 1'b1;
                        if (mem_op_s && !al_misalign_s) begin
                            state_r      <= REQ;
                            dreq_valid_r <= 1'b1;
                            dreq_addr_r  <= ADDR_W'({in_cont.valE[31:2], 2'b00});
                            dreq_wen_r   <= al_wen_s;
                            dreq_wdata_r <= DATA_W'(al_wdata_s);
                        end else begin
                            state_r        <= DONE;
                            out_valid_r    <= 1'b1;
                            out_misalign_r <= al_misalign_s;
                            out_cont_r     <= accept_cont_s;
                        end
                    end
                end
                REQ: begin
                    if (dbus.daddr_ok) begin
                        dreq_valid_r <= 1'b0;
                        if (dbus.ddata_ok) begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                            out_cont_r  <= done_cont_s;
                        end else begin
                            state_r <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dbus.ddata_ok) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                        out_cont_r  <= done_cont_s;
                    end
                end
                DONE: begin
                    state_r        <= IDLE;
                    busy_r         <= 1'b0;
                    out_valid_r    <= 1'b0;
                    out_misalign_r <= 1'b0;
                end
                default: begin
                    state_r        <= IDLE;
                    busy_r         <= 1'b0;
                    out_valid_r    <= 1'b0;
                    out_misalign_r <= 1'b0;
                    dreq_valid_r   <= 1'b0;
                end
            endcase
        end
    end

    assign busy            = busy_r;
    assign out_valid       = out_valid_r;
    assign out_cont        = out_cont_r;
    assign out_misalign    = out_misalign_r;
    assign dbus.dreq_valid = dreq_valid_r;
    assign dbus.dreq_addr  = dreq_addr_r;
    assign dbus.dreq_wen   = dreq_wen_r;
    assign dbus.dreq_wdata = dreq_wdata_r;

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access
//   Directed-vector bench for memory_access. Inputs are driven and outputs
//   sampled 1 ns after the rising edge; expected values are hand-computed.
module tb_memory_access;
    import memory_access_pkg::*;

    logic     clk = 1'b0;
    logic     resetn;
    logic     in_valid;
    content_t in_cont;
    logic     busy;
    logic     out_valid;
    content_t out_cont;
    logic     out_misalign;
    int       n_vec = 0;
    int       n_err = 0;
    int       ov_cnt = 0;
    int       snap;

    memory_access_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    memory_access #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_valid     (in_valid),
        .in_cont      (in_cont),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_cont     (out_cont),
        .out_misalign (out_misalign),
        .dbus         (bus)
    );

    always #5 clk = ~clk;

    // Count every out_valid cycle, to catch dropped or duplicated results.
    always @(negedge clk) begin
        if (out_valid) ov_cnt <= ov_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic content_t mk(op_t op, logic [31:0] e, logic [31:0] b);
        content_t c;
        c.opcode = op;
        c.dst    = 5'd3;
        c.valE   = e;
        c.valB   = b;
        c.valM   = 32'hDEAD_BEEF;
        return c;
    endfunction

    initial begin
        resetn       = 1'b0;
        in_valid     = 1'b0;
        in_cont      = '0;
        bus.daddr_ok = 1'b0;
        bus.ddata_ok = 1'b0;
        bus.drdata   = 32'h0000_0000;
        tick();
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_misalign", out_misalign, 1'b0);
        chk("rst_dreq_valid", bus.dreq_valid, 1'b0);
        chk("rst_out_cont", out_cont, 64'h0);
        resetn = 1'b1;
        tick();

        // ADDU: result one cycle after acceptance, bundle unchanged
        in_valid = 1'b1;
        in_cont  = mk(OP_ADDU, 32'h1234_5678, 32'h0000_0009);
        tick();
        in_valid = 1'b0;
        chk("addu_out_valid", out_valid, 1'b1);
        chk("addu_valE", out_cont.valE, 32'h1234_5678);
        chk("addu_valM", out_cont.valM, 32'hDEAD_BEEF);
        chk("addu_no_dreq", bus.dreq_valid, 1'b0);
        chk("addu_busy", busy, 1'b1);
        tick();
        chk("addu_out_drop", out_valid, 1'b0);
        chk("addu_idle", busy, 1'b0);

        // LB at 0x1003, bus answers address and data in the same cycle
        bus.daddr_ok = 1'b1;
        bus.ddata_ok = 1'b1;
        bus.drdata   = 32'h80AA_BBCC;
        in_valid     = 1'b1;
        in_cont      = mk(OP_LB, 32'h0000_1003, 32'h0);
        tick();
        in_valid = 1'b0;
        chk("lb_dreq_valid", bus.dreq_valid, 1'b1);
        chk("lb_dreq_addr", bus.dreq_addr, 32'h0000_1000);
        chk("lb_dreq_wen", bus.dreq_wen, 4'b0000);
        chk("lb_early_out", out_valid, 1'b0);
        tick();
        chk("lb_out_valid", out_valid, 1'b1);
        chk("lb_valM", out_cont.valM, 32'hFFFF_FF80);
        chk("lb_dreq_drop", bus.dreq_valid, 1'b0);
        tick();

        // LBU, same stimulus, zero-extended
        in_valid = 1'b1;
        in_cont  = mk(OP_LBU, 32'h0000_1003, 32'h0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("lbu_out_valid", out_valid, 1'b1);
        chk("lbu_valM", out_cont.valM, 32'h0000_0080);
        tick();
        bus.daddr_ok = 1'b0;
        bus.ddata_ok = 1'b0;

        // SH at 0x2002 with stalled address and data phases
        snap     = ov_cnt;
        in_valid = 1'b1;
        in_cont  = mk(OP_SH, 32'h0000_2002, 32'h1234_5678);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("sh_dreq_valid", bus.dreq_valid, 1'b1);
            chk("sh_dreq_addr", bus.dreq_addr, 32'h0000_2000);
            chk("sh_dreq_wen", bus.dreq_wen, 4'b1100);
            chk("sh_dreq_wdata", bus.dreq_wdata, 32'h5678_5678);
            chk("sh_busy_req", busy, 1'b1);
            tick();
        end
        bus.daddr_ok = 1'b1;
        tick();
        bus.daddr_ok = 1'b0;
        chk("sh_wait_dreq", bus.dreq_valid, 1'b0);
        chk("sh_wait_busy", busy, 1'b1);
        chk("sh_wait_no_out", out_valid, 1'b0);
        tick();
        chk("sh_wait2_busy", busy, 1'b1);
        bus.ddata_ok = 1'b1;
        tick();
        bus.ddata_ok = 1'b0;
        chk("sh_out_valid", out_valid, 1'b1);
        chk("sh_valM", out_cont.valM, 32'h0000_0000);
        chk("sh_valE", out_cont.valE, 32'h0000_2002);
        tick();
        chk("sh_out_drop", out_valid, 1'b0);
        chk("sh_pulses", ov_cnt - snap, 1);

        // LW at 0x3001: misaligned, no bus activity
        in_valid = 1'b1;
        in_cont  = mk(OP_LW, 32'h0000_3001, 32'h0);
        tick();
        in_valid = 1'b0;
        chk("lwmis_out_valid", out_valid, 1'b1);
        chk("lwmis_misalign", out_misalign, 1'b1);
        chk("lwmis_valM", out_cont.valM, 32'h0000_0000);
        chk("lwmis_no_dreq", bus.dreq_valid, 1'b0);
        tick();
        chk("lwmis_misalign_drop", out_misalign, 1'b0);

        // LH abandoned by reset while waiting for data
        snap     = ov_cnt;
        in_valid = 1'b1;
        in_cont  = mk(OP_LH, 32'h0000_4000, 32'h0);
        tick();
        in_valid     = 1'b0;
        bus.daddr_ok = 1'b1;
        tick();
        bus.daddr_ok = 1'b0;
        chk("lh_wait_busy", busy, 1'b1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("lh_rst_busy", busy, 1'b0);
        bus.ddata_ok = 1'b1;
        bus.drdata   = 32'h1111_2222;
        tick();
        bus.ddata_ok = 1'b0;
        chk("lh_stray_out", out_valid, 1'b0);
        chk("lh_stray_busy", busy, 1'b0);
        tick();
        chk("lh_no_pulse", ov_cnt - snap, 0);

        // LW then ADDU held by upstream while busy
        snap         = ov_cnt;
        bus.daddr_ok = 1'b1;
        bus.ddata_ok = 1'b1;
        bus.drdata   = 32'hCAFE_F00D;
        in_valid     = 1'b1;
        in_cont      = mk(OP_LW, 32'h0000_5004, 32'h0);
        tick();
        in_cont = mk(OP_ADDU, 32'h0000_00AB, 32'h0);
        tick();
        chk("b2b_lw_out", out_valid, 1'b1);
        chk("b2b_lw_valM", out_cont.valM, 32'hCAFE_F00D);
        chk("b2b_lw_opcode", out_cont.opcode, OP_LW);
        chk("b2b_done_busy", busy, 1'b1);
        tick();
        chk("b2b_idle_out", out_valid, 1'b0);
        chk("b2b_idle_busy", busy, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("b2b_addu_out", out_valid, 1'b1);
        chk("b2b_addu_valE", out_cont.valE, 32'h0000_00AB);
        chk("b2b_addu_opcode", out_cont.opcode, OP_ADDU);
        tick();
        tick();
        chk("b2b_pulses", ov_cnt - snap, 2);
        chk("b2b_final_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Pipeline stage directly downstream of Execute; consumes Execute's content_t bundle.
- Forwards non-memory instructions to Writeback after one register stage.
- For load/store opcodes: uses valE as the effective address, runs a request/response handshake on the data bus, and aligns and extends load data into valM.
- Raises busy so upstream stages stall while a bus transaction is outstanding.

Parameters:
- ADDR_W, 32, data-bus address width
- DATA_W, 32, data-bus data width (fixed 32; other values unsupported)

Ports:
- clk  in  1  core clock
- resetn  in  1  synchronous, active-low reset; sampled on rising clk
- in_valid  in  1  in_cont holds a valid instruction
- in_cont  in  content_t  bundle from Execute; valE = address/result, valB = store data
- busy  out  1  stage cannot accept; upstream holds in_cont
- out_valid  out  1  out_cont valid for exactly one cycle
- out_cont  out  content_t  bundle to Writeback; valM filled for loads
- out_misalign  out  1  accompanies out_valid; address misaligned for access size
- dreq_valid  out  1  data-bus request valid
- dreq_addr  out  ADDR_W  word-aligned address ({valE[31:2],2'b00})
- dreq_wen  out  4  byte strobes; 4'b0000 for loads
- dreq_wdata  out  DATA_W  store data, lane-replicated
- daddr_ok  in  1  bus accepted request this cycle
- ddata_ok  in  1  bus completed transaction this cycle
- drdata  in  DATA_W  read data, valid with ddata_ok

Behaviour:
- Reset (resetn=0 at a clk edge):
  - State goes to IDLE.
  - out_valid=0, out_misalign=0, dreq_valid=0, busy=0, out_cont='0.
  - An outstanding transaction is abandoned; later ddata_ok is ignored until a new request is issued.
- FSM states: IDLE, REQ, WAIT, DONE.
- busy = (state != IDLE).
- IDLE & in_valid: latch in_cont.
  - Non-memory opcode, or misaligned memory access → DONE. No bus activity; out_misalign set as applicable.
  - Aligned memory opcode → REQ.
- REQ:
  - dreq_valid=1; addr, wen and wdata come from the latched bundle and stay stable until daddr_ok.
  - daddr_ok & ddata_ok in the same cycle → DONE, capturing drdata.
  - daddr_ok only → WAIT.
- WAIT: dreq_valid=0; on ddata_ok capture drdata → DONE.
- DONE: out_valid=1 for one cycle with out_cont = latched bundle plus valM; → IDLE. An instruction cannot be accepted in the DONE cycle.
- Latency from acceptance edge to out_valid:
  - Non-memory: 1 cycle.
  - Memory: minimum 2 cycles; unbounded while the bus withholds ok signals.
- Misalignment rules:
  - LW/SW: addr[1:0]!=0.
  - LH/LHU/SH: addr[0]!=0.
  - Byte accesses: never misaligned.
  - Misaligned ops: valM='0, no request issued.
- Strobes:
  - SB: 4'b0001<<addr[1:0]; wdata={4{valB[7:0]}}.
  - SH: 4'b0011<<{addr[1],1'b0}; wdata={2{valB[15:0]}}.
  - SW: 4'b1111; wdata=valB.
- Load extraction:
  - Byte = drdata[8*addr[1:0] +: 8].
  - Half = drdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word.
- Stores: valM='0; out_valid still pulses on completion.
- in_valid while busy is ignored; upstream must hold the bundle.

Decomposition:
- Shared package cpuhead.svh:
  - mem_state_t enum (IDLE, REQ, WAIT, DONE).
  - Strobe constants STRB_B/STRB_H/STRB_W.
  - Helper predicates is_load(opcode) and is_store(opcode).
- Sub-module mem_align (combinational): in opcode, addr[1:0], valB, drdata; out wen, wdata, valM, misalign. Shared by request and response paths.

Test Plan:
- ADDU bundle, in_valid one cycle → out_valid exactly 1 cycle later, no dreq_valid, valE unchanged.
- LB valE=0x1003, daddr_ok & ddata_ok same cycle, drdata=0x80AA_BBCC → dreq_addr=0x1000, wen=0, valM=0xFFFF_FF80 two cycles after acceptance; LBU same stimulus → valM=0x0000_0080.
- SH valE=0x2002, valB=0x1234_5678, daddr_ok delayed 3 cycles, ddata_ok 2 cycles later → dreq held stable with wen=4'b1100, wdata=0x5678_5678; busy high throughout; out_valid once.
- LW valE=0x3001 → out_misalign=1, valM=0, no dreq_valid, out_valid 1 cycle after acceptance.
- LH issued, resetn=0 while in WAIT, stray ddata_ok after release → state IDLE, out_valid never asserted for that LH, busy=0.
- Back-to-back: LW then ADDU held by upstream under busy → ADDU accepted on first IDLE cycle after LW's DONE; outputs in order, none dropped or duplicated.
